// File: rtl/bus_timer.sv
// bus_timer: 16-bit memory-mapped interval timer on the 65C02 bus.
// Four byte registers (CNT_LO, CNT_HI, CTRL, STATUS), registered read data
// one clock after the address, and a level IRQ built from flag & IE.
module bus_timer #(
  parameter int          DIV      = 16,
  parameter logic [15:0] RESET_RL = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
);

  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  localparam logic [1:0] A_LO   = 2'd0;
  localparam logic [1:0] A_HI   = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic [15:0]   count;
  logic [15:0]   reload;
  logic [7:0]    lo_stage;
  logic [7:0]    hi_snap;
  logic [2:0]    ctrl;
  logic          flag;
  logic [PW-1:0] prescaler;

  logic en, ie, oneshot;
  logic wr_lo, wr_hi, wr_ctrl, wr_stat, rd_lo;
  logic tick, expire;

  assign en      = ctrl[0];
  assign ie      = ctrl[1];
  assign oneshot = ctrl[2];

  assign wr_lo   = cs & we & (addr == A_LO);
  assign wr_hi   = cs & we & (addr == A_HI);
  assign wr_ctrl = cs & we & (addr == A_CTRL);
  assign wr_stat = cs & we & (addr == A_STAT);
  assign rd_lo   = cs & ~we & (addr == A_LO);

  // A CNT_HI write on the same clock as a tick swallows the tick entirely,
  // so expiry is masked by wr_hi as well.
  assign tick    = en & (prescaler == PS_LAST);
  assign expire  = tick & (count == 16'd0) & ~wr_hi;

  // Both terms are flops, so irq cannot glitch and drops with either.
  assign irq     = flag & ie;

  // Prescaler: free-runs 0..DIV-1 while enabled, restarted by a reload write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   prescaler <= '0;
    else if (wr_hi) prescaler <= '0;
    else if (en)    prescaler <= tick ? '0 : prescaler + PW'(1);
  end

  // Reload staging and down-counter; count parks at 0 in one-shot mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= RESET_RL;
      reload   <= RESET_RL;
      lo_stage <= 8'h00;
    end else begin
      if (wr_lo) lo_stage <= data_in;
      if (wr_hi) begin
        reload <= {data_in, lo_stage};
        count  <= {data_in, lo_stage};
      end else if (tick) begin
        if (count == 16'd0) count <= oneshot ? 16'd0 : reload;
        else                count <= count - 16'd1;
      end
    end
  end

  // Control register; a CPU write beats the one-shot auto-disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ctrl    <= 3'b000;
    else if (wr_ctrl)            ctrl    <= data_in[2:0];
    else if (expire && oneshot)  ctrl[0] <= 1'b0;
  end

  // Expiry flag; a set on the same clock as a clear leaves it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   flag <= 1'b0;
    else if (expire)                flag <= 1'b1;
    else if (wr_stat && data_in[0]) flag <= 1'b0;
  end

  // Registered read mux; an LO read snapshots the high byte of the same
  // (pre-tick) count so the following HI read is coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_snap  <= 8'h00;
      data_out <= 8'h00;
    end else begin
      if (rd_lo) hi_snap <= count[15:8];
      case (addr)
        A_LO:    data_out <= count[7:0];
        A_HI:    data_out <= hi_snap;
        A_CTRL:  data_out <= {5'b0, ctrl};
        default: data_out <= {7'b0, flag};
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer. Expected values come from timing
// arithmetic: expiry every (reload+1)*DIV clocks after the start edge.
module tb_bus_timer;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  bus_timer #(.DIV(DIV), .RESET_RL(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .addr(addr), .we(we),
    .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus tasks are called at a negedge; the access is captured on the next
  // posedge, whose cycle number equals cyc when the task returns.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; addr = 2'($urandom); data_in = 8'($urandom);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    v = data_out; cs = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int t, output bit ok);
    ok = 1'b0; t = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (irq) begin ok = 1'b1; t = cyc; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cs = 1'($urandom); we = 1'($urandom); addr = 2'($urandom); data_in = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (data_out !== 8'h00 || irq !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: data_out=%h irq=%b expected 00/0", data_out, irq);
      end
    end
    cs = 1'b0; we = 1'b0;
    reset_n = 1'b1;
    rd(2'd2, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00", v); end
    rd(2'd3, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", v); end
    rd(2'd0, v); n_checks++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL reset_cnt_lo: got %h expected ff", v); end
    rd(2'd1, v); n_checks++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL reset_cnt_hi: got %h expected ff", v); end
  endtask

  task automatic test_periodic();
    int r, period, t0, t1, t2;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      r = (it == 0) ? 3 : int'($urandom_range(0, 4));
      period = (r + 1) * DIV;
      wr(2'd2, 8'h00); wr(2'd3, 8'h01);
      wr(2'd0, 8'(r)); wr(2'd1, 8'h00);
      wr(2'd2, 8'h03); t0 = cyc;
      wait_irq(period + 4, t1, ok); n_checks++;
      if (!ok || t1 - t0 != period) begin
        n_fail++; $display("FAIL periodic_first r=%0d: delay=%0d expected %0d", r, t1 - t0, period);
      end
      wr(2'd3, 8'h01); n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL periodic_clear r=%0d: irq=%b expected 0", r, irq); end
      wait_irq(period + 4, t2, ok); n_checks++;
      if (!ok || t2 - t1 != period) begin
        n_fail++; $display("FAIL periodic_second r=%0d: interval=%0d expected %0d", r, t2 - t1, period);
      end
    end
    wr(2'd2, 8'h00); wr(2'd3, 8'h01);
  endtask

  task automatic test_oneshot();
    int t0, t1;
    bit ok, seen;
    logic [7:0] v;
    wr(2'd0, 8'h01); wr(2'd1, 8'h00);
    wr(2'd2, 8'h07); t0 = cyc;
    wait_irq(2 * DIV + 4, t1, ok); n_checks++;
    if (!ok || t1 - t0 != 2 * DIV) begin
      n_fail++; $display("FAIL oneshot_expiry: delay=%0d expected %0d", t1 - t0, 2 * DIV);
    end
    rd(2'd2, v); n_checks++;
    if (v !== 8'h06) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected 06", v); end
    rd(2'd0, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL oneshot_cnt_lo: got %h expected 00", v); end
    rd(2'd1, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL oneshot_cnt_hi: got %h expected 00", v); end
    wr(2'd3, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL oneshot_rearm: irq=%b expected 0", seen); end
    rd(2'd3, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL oneshot_status: got %h expected 00", v); end
    wr(2'd2, 8'h00);
  endtask

  task automatic test_atomic_read();
    int t0, te;
    logic [7:0] lo, hi;
    logic [15:0] exp_pair;
    for (int off = -2; off <= 2; off++) begin
      wr(2'd2, 8'h00); wr(2'd0, 8'h00); wr(2'd1, 8'h01);
      wr(2'd2, 8'h01); t0 = cyc;
      repeat (DIV + off - 1) @(negedge clk);
      rd(2'd0, lo); te = cyc;
      rd(2'd1, hi);
      // Read edge at or before the first tick sees 0x0100, after it 0x00FF.
      exp_pair = (te <= t0 + DIV) ? 16'h0100 : 16'h00FF;
      n_checks++;
      if ({hi, lo} !== exp_pair) begin
        n_fail++; $display("FAIL atomic_read off=%0d: got %h expected %h", off, {hi, lo}, exp_pair);
      end
    end
    wr(2'd2, 8'h00);
  endtask

  task automatic test_collisions();
    int t0;
    logic [7:0] v;
    // Clear on the expiry clock: set wins. IE off, so irq must stay low.
    wr(2'd3, 8'h01); wr(2'd0, 8'h00); wr(2'd1, 8'h00);
    wr(2'd2, 8'h01); t0 = cyc;
    repeat (DIV - 1) @(negedge clk);
    wr(2'd3, 8'h01); n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: irq=%b expected 0", irq); end
    rd(2'd3, v); n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL clear_vs_expiry: status=%h expected 01", v); end
    wr(2'd3, 8'h01);
    rd(2'd3, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL clear_off_expiry: status=%h expected 00", v); end
    // Reload write on the tick clock: new value, no decrement.
    wr(2'd2, 8'h00); wr(2'd0, 8'h05); wr(2'd1, 8'h00); wr(2'd0, 8'h34);
    wr(2'd2, 8'h01); t0 = cyc;
    repeat (DIV - 1) @(negedge clk);
    wr(2'd1, 8'h12);
    wr(2'd2, 8'h00);
    rd(2'd0, v); n_checks++;
    if (v !== 8'h34) begin n_fail++; $display("FAIL hi_write_vs_tick_lo: got %h expected 34", v); end
    rd(2'd1, v); n_checks++;
    if (v !== 8'h12) begin n_fail++; $display("FAIL hi_write_vs_tick_hi: got %h expected 12", v); end
    // CTRL write on the one-shot expiry clock: the CPU value sticks.
    wr(2'd3, 8'h01); wr(2'd0, 8'h00); wr(2'd1, 8'h00);
    wr(2'd2, 8'h05); t0 = cyc;
    repeat (DIV - 1) @(negedge clk);
    wr(2'd2, 8'h01);
    rd(2'd2, v); n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL ctrl_vs_autoclear: ctrl=%h expected 01", v); end
    wr(2'd2, 8'h00);
    rd(2'd3, v); n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL oneshot_expiry_flag: status=%h expected 01", v); end
    wr(2'd3, 8'h01);
  endtask

  task automatic test_async_reset();
    int t1;
    bit ok;
    logic [7:0] v;
    wr(2'd0, 8'h03); wr(2'd1, 8'h00); wr(2'd2, 8'h03);
    wait_irq(4 * DIV + 4, t1, ok); n_checks++;
    if (!ok) begin n_fail++; $display("FAIL async_setup: irq=%b expected 1", irq); end
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: irq=%b data_out=%h expected 0/00", irq, data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, v); n_checks++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL async_cnt_lo: got %h expected ff", v); end
    rd(2'd1, v); n_checks++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL async_cnt_hi: got %h expected ff", v); end
    rd(2'd2, v); n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL async_ctrl: got %h expected 00", v); end
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; data_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_atomic_read();
    test_collisions();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
